// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// Single-edge ops: AND, OR, ADD, SUB, SLT, SLTU, plus the DIVU/REMU divide-by-zero cases
// and illegal opcodes. Multi-cycle ops: shift-add MUL and restoring DIVU/REMU, one bit per cycle.
// One operation is in flight at a time; the result is held until the consumer accepts it.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b and alu_ctrl are captured on accept
//   alu_ctrl            0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 MUL, 7 DIVU, 8 REMU, others illegal
//   a, b                operands
//   out_valid/out_ready result handshake
//   y, zero, ovf, err   result, y==0 flag, signed overflow (ADD/SUB), illegal-op / divide-by-zero
module seq_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y,
  output logic              zero,
  output logic              ovf,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // Multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;

  // Divider: partial remainder, dividend/quotient shift register, divisor.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             is_rem_q;

  logic             accept;
  logic             last_iter;
  logic             is_div_op;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] comb_y;
  logic             comb_ovf;
  logic             comb_err;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign zero      = out_valid && (y_q == '0);

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_div_op = (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);

  // Single-edge result path. DIVU/REMU entries only apply to the b==0 case;
  // a nonzero divisor takes the iterative path instead.
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    comb_y   = '0;
    comb_ovf = 1'b0;
    comb_err = 1'b0;
    case (alu_ctrl)
      OP_AND:  comb_y = a & b;
      OP_OR:   comb_y = a | b;
      OP_ADD: begin
        comb_y   = sum;
        comb_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        comb_y   = diff;
        comb_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  comb_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: comb_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  comb_y = '0;
      OP_DIVU: begin
        comb_y   = '1;
        comb_err = 1'b1;
      end
      OP_REMU: begin
        comb_y   = a;
        comb_err = 1'b1;
      end
      default: begin
        comb_y   = '0;
        comb_err = 1'b1;
      end
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_shift = {1'b0, rem_q[WIDTH-1:0]} << 1;
    rem_shift[0] = quot_q[WIDTH-1];
    rem_trial = rem_shift - {1'b0, dvsr_q};
    trial_ok  = ~rem_trial[WIDTH];
    rem_step  = trial_ok ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], trial_ok};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alu_ctrl == OP_MUL)           state_d = ST_MUL;
          else if (is_div_op && (b != '0))  state_d = ST_DIV;
          else                              state_d = ST_DONE;
        end
      end
      ST_MUL:  if (last_iter) state_d = ST_DONE;
      ST_DIV:  if (last_iter) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            rem_q    <= '0;
            quot_q   <= a;
            dvsr_q   <= b;
            is_rem_q <= (alu_ctrl == OP_REMU);
            if (state_d == ST_DONE) begin
              y_q   <= comb_y;
              ovf_q <= comb_ovf;
              err_q <= comb_err;
            end else begin
              ovf_q <= 1'b0;
              err_q <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            y_q   <= acc_step;
            cnt_q <= '0;
          end
        end
        ST_DIV: begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            y_q   <= is_rem_q ? rem_step : quot_step;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
